// File: rtl/avalon_master_bridge.sv
// avalon_master_bridge
// Sole Avalon-MM master between the CPU core and memory. Arbitrates between
// an instruction fetch port and a data load/store port (data has priority),
// keeps one bus transaction outstanding at a time, steers byte lanes for
// byte/half/word/dword accesses, flags misaligned accesses without touching
// the bus and aborts a transaction that stalls for too long.
//
// Ports:
//   clk, reset_n                        clock (rising edge), async active-low reset
//   av_address/av_read/av_write         Avalon-MM command (word-aligned address)
//   av_writedata/av_byteenable          lane-steered store data and lane enables
//   av_waitrequest/av_readdata          slave stall and zero-latency read data
//   instr_req/instr_address             fetch request, held until instr_valid
//   instr_readdata/instr_valid          fetched word and one-cycle completion pulse
//   data_req/data_we/data_size          data request, direction and access size
//   data_address/data_writedata         byte address and right-justified store data
//   data_readdata/data_valid            right-justified load data and completion pulse
//   bus_error                           qualifies the completion pulse (misaligned/timeout)
//   busy                                high whenever the bridge is not idle

module avalon_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_W-1:0]     av_address,
  output logic                  av_read,
  output logic                  av_write,
  input  logic                  av_waitrequest,
  output logic [DATA_W-1:0]     av_writedata,
  output logic [DATA_W/8-1:0]   av_byteenable,
  input  logic [DATA_W-1:0]     av_readdata,
  input  logic                  instr_req,
  input  logic [ADDR_W-1:0]     instr_address,
  output logic [31:0]           instr_readdata,
  output logic                  instr_valid,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [1:0]            data_size,
  input  logic [ADDR_W-1:0]     data_address,
  input  logic [DATA_W-1:0]     data_writedata,
  output logic [DATA_W-1:0]     data_readdata,
  output logic                  data_valid,
  output logic                  bus_error,
  output logic                  busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUS_DATA,
    BUS_INSTR,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic                r_we;
  logic [1:0]          r_size;
  logic [OFF_W-1:0]    r_off;
  logic                r_isData;
  logic                r_err;
  logic [CNT_W-1:0]    r_waitCnt;

  logic                w_anyReq;
  logic [ADDR_W-1:0]   w_reqAddr;
  logic [1:0]          w_reqSize;
  logic                w_reqWe;
  logic [OFF_W-1:0]    w_off;
  logic                w_misaligned;
  logic [BE_W-1:0]     w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_shifted;
  logic [DATA_W-1:0]   w_mask;

  // Request selection and lane steering for the access about to be latched.
  // A fetch is treated as an aligned word load on the instruction port.
  always_comb begin
    w_anyReq  = data_req | instr_req;
    w_reqAddr = data_req ? data_address : instr_address;
    w_reqSize = data_req ? data_size : 2'd2;
    w_reqWe   = data_req & data_we;
    w_off     = w_reqAddr[OFF_W-1:0];

    w_misaligned = 1'b0;
    w_be         = '1;
    case (w_reqSize)
      2'd0: w_be = BE_W'(1) << w_off;
      2'd1: begin
        w_misaligned = w_reqAddr[0];
        w_be         = BE_W'(3) << w_off;
      end
      2'd2: begin
        w_misaligned = |w_reqAddr[1:0];
        w_be         = BE_W'(4'hF) << w_off;
      end
      default: begin
        // dword only exists on a 64-bit bus
        w_misaligned = (DATA_W != 64) || (|w_reqAddr[2:0]);
        w_be         = '1;
      end
    endcase

    w_wdata = data_writedata << {w_off, 3'b000};
  end

  // Timeout fires on the stalled cycle that would bring the count to TIMEOUT,
  // so the strobe has been high for exactly TIMEOUT cycles when it drops.
  always_comb begin
    w_timeout = (TIMEOUT != 0) && av_waitrequest &&
                (r_waitCnt == CNT_W'(TIMEOUT - 1));
  end

  // Read data realignment: shift the addressed lane down and trim to size.
  always_comb begin
    w_shifted = av_readdata >> {r_off, 3'b000};
    case (r_size)
      2'd0:    w_mask = DATA_W'(8'hFF);
      2'd1:    w_mask = DATA_W'(16'hFFFF);
      2'd2:    w_mask = DATA_W'(32'hFFFF_FFFF);
      default: w_mask = '1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          if (w_misaligned) begin
            w_nextState = DONE;
          end else if (data_req) begin
            w_nextState = BUS_DATA;
          end else begin
            w_nextState = BUS_INSTR;
          end
        end
      end
      BUS_DATA, BUS_INSTR: begin
        if (!av_waitrequest || w_timeout) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic: strobes only in the bus states, pulses only in DONE.
  always_comb begin
    av_read     = ((r_state == BUS_DATA) && !r_we) || (r_state == BUS_INSTR);
    av_write    = (r_state == BUS_DATA) && r_we;
    data_valid  = (r_state == DONE) && r_isData;
    instr_valid = (r_state == DONE) && !r_isData;
    bus_error   = (r_state == DONE) && r_err;
    busy        = (r_state != IDLE);
  end

  // Transaction datapath: latch the command in IDLE, count stall cycles and
  // capture read data on the completing bus cycle. A misaligned access leaves
  // the Avalon command registers and read data untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      av_address     <= '0;
      av_writedata   <= '0;
      av_byteenable  <= '1;
      r_we           <= 1'b0;
      r_size         <= 2'd0;
      r_off          <= '0;
      r_isData       <= 1'b0;
      r_err          <= 1'b0;
      r_waitCnt      <= '0;
      data_readdata  <= '0;
      instr_readdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_isData  <= data_req;
            r_we      <= w_reqWe;
            r_size    <= w_reqSize;
            r_off     <= w_off;
            r_err     <= w_misaligned;
            r_waitCnt <= '0;
            if (!w_misaligned) begin
              av_address    <= {w_reqAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              av_byteenable <= w_be;
              av_writedata  <= w_reqWe ? w_wdata : '0;
            end
          end
        end
        BUS_DATA, BUS_INSTR: begin
          if (av_waitrequest) begin
            r_waitCnt <= r_waitCnt + 1'b1;
            if (w_timeout) begin
              r_err <= 1'b1;
            end
          end else if (r_state == BUS_INSTR) begin
            instr_readdata <= w_shifted[31:0];
          end else if (!r_we) begin
            data_readdata <= w_shifted & w_mask;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_master_bridge.sv
// tb_avalon_master_bridge
// Directed bench for avalon_master_bridge. A 32-bit instance with a short
// stall timeout carries the vector table and the priority/reset sequences;
// a 64-bit instance covers dword stores and upper-lane fetch/load steering.

module tb_avalon_master_bridge;

  logic        clk;
  logic        resetN;

  // 32-bit instance
  logic [31:0] avAddress;
  logic        avRead;
  logic        avWrite;
  logic        avWaitrequest;
  logic [31:0] avWritedata;
  logic [3:0]  avByteenable;
  logic [31:0] avReaddata;
  logic        instrReq;
  logic [31:0] instrAddress;
  logic [31:0] instrReaddata;
  logic        instrValid;
  logic        dataReq;
  logic        dataWe;
  logic [1:0]  dataSize;
  logic [31:0] dataAddress;
  logic [31:0] dataWritedata;
  logic [31:0] dataReaddata;
  logic        dataValid;
  logic        busError;
  logic        busy;

  // 64-bit instance
  logic [31:0] avAddress64;
  logic        avRead64;
  logic        avWrite64;
  logic        avWaitrequest64;
  logic [63:0] avWritedata64;
  logic [7:0]  avByteenable64;
  logic [63:0] avReaddata64;
  logic        instrReq64;
  logic [31:0] instrAddress64;
  logic [31:0] instrReaddata64;
  logic        instrValid64;
  logic        dataReq64;
  logic        dataWe64;
  logic [1:0]  dataSize64;
  logic [31:0] dataAddress64;
  logic [63:0] dataWritedata64;
  logic [63:0] dataReaddata64;
  logic        dataValid64;
  logic        busError64;
  logic        busy64;

  int checkCount;
  int failCount;

  avalon_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u32 (
    .clk(clk), .reset_n(resetN),
    .av_address(avAddress), .av_read(avRead), .av_write(avWrite),
    .av_waitrequest(avWaitrequest), .av_writedata(avWritedata),
    .av_byteenable(avByteenable), .av_readdata(avReaddata),
    .instr_req(instrReq), .instr_address(instrAddress),
    .instr_readdata(instrReaddata), .instr_valid(instrValid),
    .data_req(dataReq), .data_we(dataWe), .data_size(dataSize),
    .data_address(dataAddress), .data_writedata(dataWritedata),
    .data_readdata(dataReaddata), .data_valid(dataValid),
    .bus_error(busError), .busy(busy)
  );

  avalon_master_bridge #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(255)) u64 (
    .clk(clk), .reset_n(resetN),
    .av_address(avAddress64), .av_read(avRead64), .av_write(avWrite64),
    .av_waitrequest(avWaitrequest64), .av_writedata(avWritedata64),
    .av_byteenable(avByteenable64), .av_readdata(avReaddata64),
    .instr_req(instrReq64), .instr_address(instrAddress64),
    .instr_readdata(instrReaddata64), .instr_valid(instrValid64),
    .data_req(dataReq64), .data_we(dataWe64), .data_size(dataSize64),
    .data_address(dataAddress64), .data_writedata(dataWritedata64),
    .data_readdata(dataReaddata64), .data_valid(dataValid64),
    .bus_error(busError64), .busy(busy64)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    bit          isInstr;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    int          expStrobes;
    int          expLatency;
    bit          expErr;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string name, bit isInstr, bit we, logic [1:0] size,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                              int waits, int expStrobes, int expLatency, bit expErr,
                              logic [31:0] expAddr, logic [3:0] expBe,
                              logic [31:0] expWdata, logic [31:0] expRd);
    vec_t v;
    v.name = name; v.isInstr = isInstr; v.we = we; v.size = size;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.waits = waits;
    v.expStrobes = expStrobes; v.expLatency = expLatency; v.expErr = expErr;
    v.expAddr = expAddr; v.expBe = expBe; v.expWdata = expWdata; v.expRd = expRd;
    return v;
  endfunction

  // One comparison: counts it, reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Drives one access on the 32-bit instance, plays the slave (stalling for
  // v.waits strobe cycles) and compares what was seen against the vector.
  task automatic applyStimulus(input vec_t v);
    int          cyc;
    int          strobes;
    bit          gotValid;
    bit          sawOther;
    bit          sawBoth;
    bit          held;
    bit          capWrite;
    bit          err;
    logic [31:0] capAddr;
    logic [3:0]  capBe;
    logic [31:0] capWdata;
    logic [31:0] rd;
    cyc = 0; strobes = 0; gotValid = 0; sawOther = 0; sawBoth = 0; held = 1;
    capWrite = 0; err = 0; capAddr = '0; capBe = '0; capWdata = '0; rd = '0;

    @(negedge clk);
    if (v.isInstr) begin
      instrReq = 1'b1;
      instrAddress = v.addr;
    end else begin
      dataReq = 1'b1;
      dataWe = v.we;
      dataSize = v.size;
      dataAddress = v.addr;
      dataWritedata = v.wdata;
    end
    avWaitrequest = 1'b0;
    avReaddata = v.rdata;

    while (!gotValid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (avRead && avWrite) sawBoth = 1;
      if (avRead || avWrite) begin
        strobes++;
        if (strobes == 1) begin
          capAddr = avAddress; capBe = avByteenable;
          capWdata = avWritedata; capWrite = avWrite;
        end else if (avAddress !== capAddr || avByteenable !== capBe ||
                     avWritedata !== capWdata) begin
          held = 0;
        end
        avWaitrequest = (strobes <= v.waits);
      end else begin
        avWaitrequest = 1'b0;
      end
      if (v.isInstr ? instrValid : dataValid) begin
        gotValid = 1;
        err = busError;
        rd = v.isInstr ? instrReaddata : dataReaddata;
        instrReq = 1'b0;
        dataReq = 1'b0;
      end
      if (v.isInstr ? dataValid : instrValid) sawOther = 1;
    end
    avWaitrequest = 1'b0;
    instrReq = 1'b0;
    dataReq = 1'b0;

    checkOutput({v.name, ".latency"}, 64'(cyc), 64'(v.expLatency));
    checkOutput({v.name, ".strobes"}, 64'(strobes), 64'(v.expStrobes));
    checkOutput({v.name, ".busError"}, 64'(err), 64'(v.expErr));
    checkOutput({v.name, ".readdata"}, 64'(rd), 64'(v.expRd));
    checkOutput({v.name, ".otherPortPulse"}, 64'(sawOther), 64'd0);
    checkOutput({v.name, ".readAndWrite"}, 64'(sawBoth), 64'd0);
    if (v.expStrobes > 0) begin
      checkOutput({v.name, ".avAddress"}, 64'(capAddr), 64'(v.expAddr));
      checkOutput({v.name, ".byteenable"}, 64'(capBe), 64'(v.expBe));
      checkOutput({v.name, ".isWrite"}, 64'(capWrite), 64'(v.we));
      checkOutput({v.name, ".heldStable"}, 64'(held), 64'd1);
      if (v.we) checkOutput({v.name, ".writedata"}, 64'(capWdata), 64'(v.expWdata));
    end
  endtask

  // Single access on the 64-bit instance with a never-stalling slave.
  task automatic run64(input bit isInstr, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdata,
                       output logic [31:0] capAddr, output logic [7:0] capBe,
                       output logic [63:0] capWdata, output logic [63:0] rd,
                       output bit err, output bit ok);
    int cyc;
    capAddr = '0; capBe = '0; capWdata = '0; rd = '0; err = 0; ok = 0; cyc = 0;
    @(negedge clk);
    if (isInstr) begin
      instrReq64 = 1'b1; instrAddress64 = addr;
    end else begin
      dataReq64 = 1'b1; dataWe64 = we; dataSize64 = size;
      dataAddress64 = addr; dataWritedata64 = wdata;
    end
    avReaddata64 = rdata;
    while (!ok && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (avRead64 || avWrite64) begin
        capAddr = avAddress64; capBe = avByteenable64; capWdata = avWritedata64;
      end
      if (isInstr ? instrValid64 : dataValid64) begin
        ok = 1; err = busError64;
        rd = isInstr ? 64'(instrReaddata64) : dataReaddata64;
      end
    end
    instrReq64 = 1'b0;
    dataReq64 = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          dataValidCyc;
    int          instrValidCyc;
    int          instrStrobeCyc;
    bit          sawValid;
    logic [31:0] capAddr;
    logic [7:0]  capBe;
    logic [63:0] capWdata;
    logic [63:0] rd;
    bit          err;
    bit          ok;

    checkCount = 0;
    failCount = 0;

    vecs[0]  = mk("ldWord",      0, 0, 2'd0 + 2'd2, 32'h104, 32'h0,        32'hDEADBEEF, 2,   3, 4, 0, 32'h104, 4'hF, 32'h0,        32'hDEADBEEF);
    vecs[1]  = mk("stByte",      0, 1, 2'd0, 32'h203, 32'h000000A5, 32'h0,        0,   1, 2, 0, 32'h200, 4'h8, 32'hA5000000, 32'hDEADBEEF);
    vecs[2]  = mk("ldHalf",      0, 0, 2'd1, 32'h202, 32'h0,        32'h1234ABCD, 0,   1, 2, 0, 32'h200, 4'hC, 32'h0,        32'h00001234);
    vecs[3]  = mk("ldByte",      0, 0, 2'd0, 32'h301, 32'h0,        32'h11223344, 1,   2, 3, 0, 32'h300, 4'h2, 32'h0,        32'h00000033);
    vecs[4]  = mk("stHalf",      0, 1, 2'd1, 32'h402, 32'h0000BEEF, 32'h0,        0,   1, 2, 0, 32'h400, 4'hC, 32'hBEEF0000, 32'h00000033);
    vecs[5]  = mk("ldWordMis",   0, 0, 2'd2, 32'h101, 32'h0,        32'h55555555, 0,   0, 1, 1, 32'h0,   4'h0, 32'h0,        32'h00000033);
    vecs[6]  = mk("stHalfMis",   0, 1, 2'd1, 32'h203, 32'h1111,     32'h0,        0,   0, 1, 1, 32'h0,   4'h0, 32'h0,        32'h00000033);
    vecs[7]  = mk("ldDword32",   0, 0, 2'd3, 32'h0,   32'h0,        32'h66666666, 0,   0, 1, 1, 32'h0,   4'h0, 32'h0,        32'h00000033);
    vecs[8]  = mk("fetch",       1, 0, 2'd2, 32'h40,  32'h0,        32'h8C220004, 0,   1, 2, 0, 32'h40,  4'hF, 32'h0,        32'h8C220004);
    vecs[9]  = mk("ldTimeout",   0, 0, 2'd2, 32'h500, 32'h0,        32'hFFFFFFFF, 100, 4, 5, 1, 32'h500, 4'hF, 32'h0,        32'h00000033);
    vecs[10] = mk("fetchAfterTo",1, 0, 2'd2, 32'h44,  32'h0,        32'h00000013, 1,   2, 3, 0, 32'h44,  4'hF, 32'h0,        32'h00000013);
    vecs[11] = mk("fetchMis",    1, 0, 2'd2, 32'h46,  32'h0,        32'h77777777, 0,   0, 1, 1, 32'h0,   4'h0, 32'h0,        32'h00000013);
    vecs[12] = mk("stWordWait3", 0, 1, 2'd2, 32'h600, 32'hCAFEF00D, 32'h0,        3,   4, 5, 0, 32'h600, 4'hF, 32'hCAFEF00D, 32'h00000033);

    resetN = 1'b0;
    avWaitrequest = 0; avReaddata = '0;
    instrReq = 0; instrAddress = '0;
    dataReq = 0; dataWe = 0; dataSize = '0; dataAddress = '0; dataWritedata = '0;
    avWaitrequest64 = 0; avReaddata64 = '0;
    instrReq64 = 0; instrAddress64 = '0;
    dataReq64 = 0; dataWe64 = 0; dataSize64 = '0; dataAddress64 = '0; dataWritedata64 = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset.avRead", 64'(avRead), 64'd0);
    checkOutput("reset.avWrite", 64'(avWrite), 64'd0);
    checkOutput("reset.byteenable", 64'(avByteenable), 64'hF);
    checkOutput("reset.byteenable64", 64'(avByteenable64), 64'hFF);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.valids", 64'({dataValid, instrValid, busError}), 64'd0);
    checkOutput("reset.dataReaddata", 64'(dataReaddata), 64'd0);
    checkOutput("reset.avAddress", 64'(avAddress), 64'd0);
    resetN = 1'b1;
    @(negedge clk);

    // Vector table on the 32-bit instance.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
    end

    // Simultaneous requests: data first, fetch begins after DONE.
    @(negedge clk);
    dataReq = 1; dataWe = 0; dataSize = 2'd2; dataAddress = 32'h10;
    instrReq = 1; instrAddress = 32'h20;
    avWaitrequest = 0;
    avReaddata = 32'h0;
    cyc = 0; dataValidCyc = -1; instrValidCyc = -1; instrStrobeCyc = -1;
    while (instrValidCyc < 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      avReaddata = (avAddress == 32'h10) ? 32'h11111111 : 32'h22222222;
      if (avRead && avAddress == 32'h20 && instrStrobeCyc < 0) instrStrobeCyc = cyc;
      if (dataValid) begin
        dataValidCyc = cyc;
        dataReq = 0;
      end
      if (instrValid) begin
        instrValidCyc = cyc;
        instrReq = 0;
      end
    end
    instrReq = 0; dataReq = 0;
    checkOutput("prio.dataValidCycle", 64'(dataValidCyc), 64'd2);
    checkOutput("prio.instrStrobeCycle", 64'(instrStrobeCyc), 64'd4);
    checkOutput("prio.instrValidCycle", 64'(instrValidCyc), 64'd5);
    checkOutput("prio.dataReaddata", 64'(dataReaddata), 64'h11111111);
    checkOutput("prio.instrReaddata", 64'(instrReaddata), 64'h22222222);

    // Reset in the middle of a stalled fetch.
    @(negedge clk);
    instrReq = 1; instrAddress = 32'h80; avWaitrequest = 1;
    @(negedge clk);
    checkOutput("midReset.strobeBefore", 64'(avRead), 64'd1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("midReset.avReadDrop", 64'(avRead), 64'd0);
    checkOutput("midReset.busy", 64'(busy), 64'd0);
    checkOutput("midReset.byteenable", 64'(avByteenable), 64'hF);
    sawValid = 0;
    repeat (2) begin
      @(negedge clk);
      if (instrValid || dataValid) sawValid = 1;
    end
    instrReq = 0; avWaitrequest = 0;
    resetN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (instrValid || dataValid) sawValid = 1;
    end
    checkOutput("midReset.noValid", 64'(sawValid), 64'd0);
    checkOutput("midReset.idleAfter", 64'(busy), 64'd0);

    // 64-bit bus: dword store, upper-lane fetch, upper-lane half load.
    run64(0, 1, 2'd3, 32'h8, 64'h0123456789ABCDEF, 64'h0, capAddr, capBe, capWdata, rd, err, ok);
    checkOutput("dw64.completed", 64'(ok), 64'd1);
    checkOutput("dw64.avAddress", 64'(capAddr), 64'h8);
    checkOutput("dw64.byteenable", 64'(capBe), 64'hFF);
    checkOutput("dw64.writedata", capWdata, 64'h0123456789ABCDEF);
    checkOutput("dw64.busError", 64'(err), 64'd0);

    run64(1, 0, 2'd2, 32'hC, 64'h0, 64'hAABBCCDD11223344, capAddr, capBe, capWdata, rd, err, ok);
    checkOutput("fetch64.completed", 64'(ok), 64'd1);
    checkOutput("fetch64.avAddress", 64'(capAddr), 64'h8);
    checkOutput("fetch64.byteenable", 64'(capBe), 64'hF0);
    checkOutput("fetch64.readdata", rd, 64'hAABBCCDD);

    run64(0, 0, 2'd1, 32'h16, 64'h0, 64'h1122334455667788, capAddr, capBe, capWdata, rd, err, ok);
    checkOutput("half64.completed", 64'(ok), 64'd1);
    checkOutput("half64.byteenable", 64'(capBe), 64'hC0);
    checkOutput("half64.readdata", rd, 64'h1122);

    run64(0, 0, 2'd3, 32'h14, 64'h0, 64'h0, capAddr, capBe, capWdata, rd, err, ok);
    checkOutput("dwMis64.busError", 64'(err), 64'd1);
    checkOutput("dwMis64.readdataKept", rd, 64'h1122);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
